// File: rtl/nios_button_pkg.sv
// Shared constants for the push-button debounce controller: register map
// addresses and the idle (released) level of an active-low button.
package nios_button_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_MASK = 2'd1,
    ADDR_EDGE = 2'd2,
    ADDR_RAW  = 2'd3
  } reg_addr_e;

  localparam logic RELEASED = 1'b1;

endpackage

// File: rtl/button_debounce_bit.sv
// One button: 2-flop synchroniser, tick-based debounce counter and the
// debounced level, with a single-cycle press pulse on a 1->0 change.
module button_debounce_bit
  import nios_button_pkg::*;
#(
  parameter int STABLE_TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pin,
  output logic sync,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          meta;
  logic [CW-1:0] cnt;
  logic          flip;

  // The pulse is combinational so EDGE is set on the same edge that stable changes.
  assign flip  = tick && (sync != stable) && (cnt == CNT_LAST);
  assign press = flip && !sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser to one stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RELEASED;
      sync <= RELEASED;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= RELEASED;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nios_button_debounce_ctrl.sv
// Avalon-MM push-button controller: shared sample-tick prescaler, per-button
// debouncers, press-event latch with W1C clear, interrupt mask and read mux.
module nios_button_debounce_ctrl
  import nios_button_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre;
  logic             tick;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] edge_lat;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    button_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .pin   (in_port[i]),
      .sync  (sync[i]),
      .stable(stable[i]),
      .press (press[i])
    );
  end

  assign edge_clr = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // A press landing in the same cycle as its W1C clear must survive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_lat <= '0;
      mask     <= '0;
      irq      <= 1'b0;
    end else begin
      edge_lat <= (edge_lat & ~edge_clr) | press;
      if (write && address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
      irq <= |(edge_lat & mask);
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = 32'(stable);
      ADDR_MASK: rd_mux = 32'(mask);
      ADDR_EDGE: rd_mux = 32'(edge_lat);
      ADDR_RAW:  rd_mux = 32'(sync);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     readdata <= '0;
    else if (read) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_nios_button_debounce_ctrl.sv
// Self-checking bench: directed scenarios plus a random phase, every cycle
// compared against an arithmetic model of the debounce and register rules.
module tb_nios_button_debounce_ctrl;

  localparam int WIDTH        = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_port;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  nios_button_debounce_ctrl #(
    .WIDTH       (WIDTH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_port  (in_port),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Reference model. Edge k is the k-th rising edge after reset release;
  // ticks fall on edges where k mod TICK_DIV == TICK_DIV-1, and a pin value
  // presented at edge j is the synchronised level seen at edge j+2.
  int          k;
  logic [3:0]  pin_q[$];
  logic [3:0]  m_stable;
  logic [3:0]  m_edge;
  logic [3:0]  m_mask;
  int          m_last_match[4];
  logic [31:0] m_rdata;
  logic        m_irq;

  function automatic int ticks_upto(input int c);
    return (c + 1) / TICK_DIV;
  endfunction

  function automatic logic [3:0] sync_at(input int c);
    return (c >= 2) ? pin_q[c-2] : 4'hF;
  endfunction

  // Stable flips at a tick once sync has differed for STABLE_TICKS ticks in a row.
  function automatic logic flip_due(input int b);
    logic [3:0] s;
    s = sync_at(k);
    return (s[b] != m_stable[b]) && (k % TICK_DIV == TICK_DIV - 1) &&
           (ticks_upto(k) - ticks_upto(m_last_match[b]) == STABLE_TICKS);
  endfunction

  function automatic logic press_next(input int b);
    logic [3:0] s;
    s = sync_at(k);
    return flip_due(b) && !s[b];
  endfunction

  function automatic int pending_ticks(input int b);
    return ticks_upto(k - 1) - ticks_upto(m_last_match[b]);
  endfunction

  task automatic model_reset();
    k = 0;
    pin_q.delete();
    m_stable = 4'hF;
    m_edge   = 4'h0;
    m_mask   = 4'h0;
    for (int b = 0; b < 4; b++) m_last_match[b] = -1;
    m_rdata = 32'h0;
    m_irq   = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] pin, input logic rd, input logic wr,
                            input logic [1:0] a, input logic [31:0] wd);
    logic [3:0] s, st_old, ed_old, mk_old, prs, clr;
    s = sync_at(k);
    st_old = m_stable;
    ed_old = m_edge;
    mk_old = m_mask;
    prs = 4'h0;
    for (int b = 0; b < 4; b++) begin
      if (s[b] == m_stable[b]) begin
        m_last_match[b] = k;
      end else if (flip_due(b)) begin
        prs[b] = !s[b];
        m_stable[b] = s[b];
        m_last_match[b] = k;
      end
    end
    if (rd) begin
      case (a)
        2'd0:    m_rdata = {28'h0, st_old};
        2'd1:    m_rdata = {28'h0, mk_old};
        2'd2:    m_rdata = {28'h0, ed_old};
        default: m_rdata = {28'h0, s};
      endcase
    end
    if (wr && a == 2'd1) m_mask = wd[3:0];
    clr = (wr && a == 2'd2) ? wd[3:0] : 4'h0;
    m_edge = (ed_old & ~clr) | prs;
    m_irq = |(ed_old & mk_old);
    pin_q.push_back(pin);
    k++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [3:0] pin, input logic rd, input logic wr,
                      input logic [1:0] a, input logic [31:0] wd);
    in_port   = pin;
    read      = rd;
    write     = wr;
    address   = a;
    writedata = wd;
    @(posedge clk);
    model_edge(pin, rd, wr, a, wd);
    #1;
    check("cycle_readdata", readdata, m_rdata);
    check("cycle_irq", 32'(irq), 32'(m_irq));
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] pin);
    in_port   = pin;
    read      = 1'b0;
    write     = 1'b0;
    address   = 2'd0;
    writedata = 32'h0;
    reset     = 1'b1;
    #1;
    model_reset();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_rst[4];
    logic [3:0]  pin;
    logic [3:0]  lvl;
    int          hold[4];
    int          first;
    int          r;
    logic        hit;

    exp_rst = '{32'hF, 32'h0, 32'h0, 32'hF};

    // 1: reset values of every register
    @(negedge clk);
    do_reset(4'hF);
    for (int a = 0; a < 4; a++) begin
      step(4'hF, 1'b1, 1'b0, 2'(a), 32'h0);
      check($sformatf("reset_reg%0d", a), readdata, exp_rst[a]);
    end
    check("reset_irq_idle", 32'(irq), 32'h0);

    // 2: steady press on bit 0 reaches DATA within the latency bound
    pin = 4'b1110;
    for (int i = 0; i < 2 + 12 + 4; i++) begin
      step(pin, 1'b1, 1'b0, 2'd0, 32'h0);
      if (readdata == 32'hE) break;
    end
    check("press_data", readdata, 32'hE);
    step(pin, 1'b1, 1'b0, 2'd2, 32'h0);
    check("press_edge", readdata, 32'h1);
    check("press_irq_masked", 32'(irq), 32'h0);

    // 3: unmask raises irq, W1C drops it
    step(pin, 1'b0, 1'b1, 2'd1, 32'h1);
    step(pin, 1'b1, 1'b0, 2'd1, 32'h0);
    check("mask_irq_set", 32'(irq), 32'h1);
    check("mask_readback", readdata, 32'h1);
    step(pin, 1'b0, 1'b1, 2'd2, 32'h1);
    step(pin, 1'b1, 1'b0, 2'd2, 32'h0);
    check("w1c_irq_clear", 32'(irq), 32'h0);
    check("w1c_edge_clear", readdata, 32'h0);

    // 4: bit 1 bounces for only 2 ticks at a time
    for (int rep = 0; rep < 5; rep++) begin
      for (int c = 0; c < 2 * TICK_DIV; c++) begin
        step(4'b1100, 1'b1, 1'b0, (c == 3) ? 2'd3 : 2'(c % 4), 32'h0);
        if (c == 3) check("bounce_raw_low", readdata, 32'hC);
      end
      for (int c = 0; c < 2 * TICK_DIV; c++) begin
        step(4'b1110, 1'b1, 1'b0, (c == 3) ? 2'd3 : 2'(c % 4), 32'h0);
        if (c == 3) check("bounce_raw_high", readdata, 32'hE);
      end
    end
    step(4'b1110, 1'b1, 1'b0, 2'd0, 32'h0);
    check("bounce_data", readdata, 32'hE);
    step(4'b1110, 1'b1, 1'b0, 2'd2, 32'h0);
    check("bounce_edge", readdata, 32'h0);

    // 5: W1C of bit 1 in the very cycle its press registers
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (press_next(1)) begin
        step(4'b1100, 1'b1, 1'b1, 2'd2, 32'h2);
        hit = 1'b1;
        break;
      end
      step(4'b1100, 1'b1, 1'b0, 2'(i % 4), 32'h0);
    end
    check("collide_reached", 32'(hit), 32'h1);
    step(4'b1100, 1'b1, 1'b0, 2'd2, 32'h0);
    check("collide_set_wins", readdata, 32'h2);

    // 6: reset after 2 ticks of a press discards the progress
    do_reset(4'hF);
    for (int i = 0; i < 4; i++) step(4'hF, 1'b1, 1'b0, 2'(i), 32'h0);
    for (int i = 0; i < 20 && pending_ticks(2) < 2; i++)
      step(4'b1011, 1'b1, 1'b0, 2'd0, 32'h0);
    check("mid_reached_2_ticks", 32'(pending_ticks(2)), 32'h2);
    do_reset(4'b1011);
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step(4'b1011, 1'b1, 1'b0, 2'd0, 32'h0);
      if (readdata == 32'hB && first < 0) first = i;
    end
    check("mid_restart_latency", 32'(first), 32'd12);

    // Random phase: bouncy pins with random register traffic
    do_reset(4'hF);
    lvl = 4'hF;
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 24));
        end
        hold[b]--;
      end
      r = int'($urandom_range(0, 9));
      if (r < 2)
        step(lvl, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), $urandom);
      else if (r == 2)
        step(lvl, 1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF);
      else
        step(lvl, 1'b1, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
